rect_motion_ctl: RTL

- Motion controller for the image rectangle: produces the rectangle position `xpos`/`ypos` consumed by the rectangle draw stage.
- Updates once per frame; the frame tick comes from `vsync`.
- While following, the rectangle tracks the mouse. A left-button press drops it under constant gravity, with damped floor bounces until it comes to rest. A further press returns it to mouse tracking.
- Sits in the 40 MHz pixel domain. Mouse position and button arrive already synchronized.

---
 rtl/rect_motion_pkg.sv | 25 ++
 rtl/rect_motion_ctl_edge_pulse.sv | 19 +
 rtl/rect_motion_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rect_motion_pkg.sv
// Shared types and default geometry for the rectangle motion controller.
package rect_motion_pkg;

    typedef logic [11:0] pos_t;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        FALL   = 2'd1,
        BOUNCE = 2'd2,
        REST   = 2'd3
    } motion_state_e;

    localparam int DEF_H_RES  = 800;
    localparam int DEF_V_RES  = 600;
    localparam int DEF_RECT_W = 48;
    localparam int DEF_RECT_H = 64;

    // Unsigned add that pins at all-ones instead of wrapping.
    function automatic pos_t sat_add(input pos_t a, input pos_t b);
        logic [12:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction

endpackage

// File: rtl/rect_motion_ctl_edge_pulse.sv
// One-register rising-edge detector: pulse is high for the cycle where d is
// high and its registered copy is still low.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/rect_motion_ctl.sv
// Per-frame motion controller for the image rectangle (follow / fall / bounce / rest).
// Bounce and damping are built only with RECT_MOTION_BOUNCE_EN defined; otherwise a floor hit rests.
module rect_motion_ctl
    import rect_motion_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int RECT_W       = DEF_RECT_W,
    parameter int RECT_H       = DEF_RECT_H,
    parameter int G_ACC        = 1,
    parameter int BOUNCE_SHIFT = 1,
    parameter int V_MIN        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        left,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state
);

    localparam pos_t FLOOR = pos_t'(V_RES - RECT_H);
    localparam pos_t X_MAX = pos_t'(H_RES - RECT_W);
    localparam pos_t G_P   = pos_t'(G_ACC);

    logic tick;
    logic press;

    edge_pulse u_vsync_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (vsync),
        .pulse (tick)
    );

    edge_pulse u_left_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (left),
        .pulse (press)
    );

    motion_state_e state_q, state_d;
    pos_t          xpos_q, xpos_d;
    pos_t          ypos_q, ypos_d;
    pos_t          vel_q, vel_d;

    pos_t        fall_vel;
    logic [12:0] fall_sum;

`ifdef RECT_MOTION_BOUNCE_EN
    localparam pos_t V_MIN_P = pos_t'(V_MIN);
    pos_t damped_vel;
    pos_t rise_vel;
    assign damped_vel = fall_vel >> BOUNCE_SHIFT;
    assign rise_vel   = (vel_q > G_P) ? (vel_q - G_P) : '0;
`else
    logic cfg_unused;
    assign cfg_unused = (BOUNCE_SHIFT != 0) ^ (V_MIN != 0);
`endif

    // Falling step uses the already-accelerated velocity; 13 bits catch overflow.
    assign fall_vel = sat_add(vel_q, G_P);
    assign fall_sum = {1'b0, ypos_q} + {1'b0, fall_vel};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FOLLOW;
            xpos_q  <= '0;
            ypos_q  <= '0;
            vel_q   <= '0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            vel_q   <= vel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        case (state_q)
            FOLLOW: begin
                if (tick) begin
                    xpos_d = (mouse_xpos > X_MAX) ? X_MAX : mouse_xpos;
                    ypos_d = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
                end
                if (press) begin
                    vel_d   = '0;
                    state_d = FALL;
                end
            end
            FALL: begin
                if (tick) begin
                    if (fall_sum >= {1'b0, FLOOR}) begin
                        ypos_d = FLOOR;
`ifdef RECT_MOTION_BOUNCE_EN
                        if (damped_vel < V_MIN_P) begin
                            vel_d   = '0;
                            state_d = REST;
                        end else begin
                            vel_d   = damped_vel;
                            state_d = BOUNCE;
                        end
`else
                        vel_d   = '0;
                        state_d = REST;
`endif
                    end else begin
                        ypos_d = fall_sum[11:0];
                        vel_d  = fall_vel;
                    end
                end
            end
            BOUNCE: begin
`ifdef RECT_MOTION_BOUNCE_EN
                if (tick) begin
                    // Rising past the top edge ends the bounce at y=0.
                    if (ypos_q <= vel_q) begin
                        ypos_d  = '0;
                        vel_d   = '0;
                        state_d = FALL;
                    end else begin
                        ypos_d = ypos_q - vel_q;
                        vel_d  = rise_vel;
                        if (rise_vel == '0) state_d = FALL;
                    end
                end
`else
                state_d = FALL;
`endif
            end
            REST: begin
                if (press) state_d = FOLLOW;
            end
            default: state_d = FOLLOW;
        endcase
    end

    assign xpos  = xpos_q;
    assign ypos  = ypos_q;
    assign state = state_q;

endmodule
